branch_unit: RTL

- Registered branch-resolution stage for the tau processor. Evaluates conditional jumps against the flag byte and produces the next fetch address one cycle later.
- Adds CALL/RET through an internal parametrised return-address stack, with overflow and underflow detection.
- Sits between decode (instruction, peeked operand word) and the program counter register.

---
 rtl/tau_isa_pkg.sv | 12 +
 rtl/branch_unit_if.sv | 27 ++
 rtl/return_address_stack.sv | 36 +++
 rtl/branch_unit.sv | 86 ++++++++
 4 files changed

// File: rtl/tau_isa_pkg.sv
// tau_isa_pkg: shared opcode and flag encodings for the tau processor
package tau_isa_pkg;
  typedef enum logic [7:0] {
    JMP  = 8'h14, JE   = 8'h15, JNE = 8'h16, JC  = 8'h17, JNC = 8'h18,
    JS   = 8'h19, JNS  = 8'h1A, JO  = 8'h1B, JNO = 8'h1C, JA  = 8'h1D,
    JAE  = 8'h1E, JB   = 8'h1F, JBE = 8'h20, JG  = 8'h21, JGE = 8'h22,
    JL   = 8'h23, JLE  = 8'h24, CALL = 8'h25, RET = 8'h26
  } jump_instruction_enum;
  typedef enum logic [2:0] {
    OVERFLOW = 3'd4, CARRY = 3'd5, SIGN = 3'd6, ZERO = 3'd7
  } flag_name_enum;
endpackage

// File: rtl/branch_unit_if.sv
// branch_unit_if: decode-side request and resolved fetch-address bundle
interface branch_unit_if #(
  parameter int WORD_SIZE = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  logic                 instr_valid;
  logic [WORD_SIZE-1:0] program_counter_address;
  logic [WORD_SIZE-1:0] instruction;
  logic [WORD_SIZE-1:0] peek_jump_address;
  logic [7:0]           flags;
  logic                 stack_clear;
  logic [WORD_SIZE-1:0] new_address;
  logic                 address_valid;
  logic                 taken;
  logic [CW-1:0]        stack_count;
  logic                 stack_overflow;
  logic                 stack_underflow;
  modport master (
    output instr_valid, program_counter_address, instruction, peek_jump_address, flags, stack_clear,
    input  new_address, address_valid, taken, stack_count, stack_overflow, stack_underflow
  );
  modport slave (
    input  instr_valid, program_counter_address, instruction, peek_jump_address, flags, stack_clear,
    output new_address, address_valid, taken, stack_count, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/return_address_stack.sv
// return_address_stack: LIFO of return addresses with clear priority over push/pop
module return_address_stack #(
  parameter int WORD_SIZE = 16,
  parameter int STACK_DEPTH = 8,
  localparam int CW = $clog2(STACK_DEPTH + 1),
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clear,
  input  logic [WORD_SIZE-1:0] push_data,
  output logic [WORD_SIZE-1:0] top,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);
  logic [WORD_SIZE-1:0] mem [STACK_DEPTH];
  logic [CW-1:0] count_m1;
  logic do_push, do_pop;
  assign full     = count == CW'(STACK_DEPTH);
  assign empty    = count == '0;
  assign count_m1 = count - CW'(1);
  assign top      = mem[count_m1[IW-1:0]];
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (do_push) count <= count + CW'(1);
    else if (do_pop) count <= count_m1;
  // entries beyond count are don't-care, so the array needs no reset
  always_ff @(posedge clk)
    if (do_push) mem[count[IW-1:0]] <= push_data;
endmodule

// File: rtl/branch_unit.sv
// branch_unit: registered jump/call/return resolution producing the next fetch address
module branch_unit
  import tau_isa_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int STACK_DEPTH = 8,
  parameter int PC_INCREMENT = 2
) (
  input logic         clk,
  input logic         reset,
  branch_unit_if.slave bus
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  function automatic logic cond_met(input logic [7:0] op, input logic [7:0] f);
    logic z, s, c, o;
    z = f[ZERO];
    s = f[SIGN];
    c = f[CARRY];
    o = f[OVERFLOW];
    case (op)
      JMP, CALL: cond_met = 1'b1;
      JE:  cond_met = z;
      JNE: cond_met = !z;
      JC:  cond_met = c;
      JNC: cond_met = !c;
      JS:  cond_met = s;
      JNS: cond_met = !s;
      JO:  cond_met = o;
      JNO: cond_met = !o;
      JA:  cond_met = !c && !z;
      JAE: cond_met = !c;
      JB:  cond_met = c;
      JBE: cond_met = c || z;
      JG:  cond_met = !((s ^ o) || z);
      JGE: cond_met = !(s ^ o);
      JL:  cond_met = s ^ o;
      JLE: cond_met = (s ^ o) || z;
      default: cond_met = 1'b0;
    endcase
  endfunction
  logic [7:0] op;
  logic [WORD_SIZE-1:0] seq, top, next_address;
  logic is_call, is_ret, ret_ok, take, full, empty;
  logic unused;
  assign op      = bus.instruction[15:8];
  assign unused  = ^{bus.instruction[7:0], bus.flags[3:0]};
  assign seq     = bus.program_counter_address + WORD_SIZE'(PC_INCREMENT);
  assign is_call = op == CALL;
  assign is_ret  = op == RET;
  assign ret_ok  = is_ret && !empty && !bus.stack_clear;
  assign take    = is_ret ? ret_ok : cond_met(op, bus.flags);
  assign next_address = is_ret ? (ret_ok ? top : seq) : (take ? bus.peek_jump_address : seq);
  return_address_stack #(.WORD_SIZE(WORD_SIZE), .STACK_DEPTH(STACK_DEPTH)) ras (
    .clk(clk),
    .reset(reset),
    .push(bus.instr_valid && is_call),
    .pop(bus.instr_valid && is_ret),
    .clear(bus.stack_clear),
    .push_data(seq),
    .top(top),
    .count(bus.stack_count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.new_address     <= '0;
      bus.address_valid   <= 1'b0;
      bus.taken           <= 1'b0;
      bus.stack_overflow  <= 1'b0;
      bus.stack_underflow <= 1'b0;
    end else begin
      bus.address_valid <= bus.instr_valid;
      bus.taken         <= bus.instr_valid && take;
      if (bus.instr_valid) bus.new_address <= next_address;
      if (bus.stack_clear) begin
        bus.stack_overflow  <= 1'b0;
        bus.stack_underflow <= 1'b0;
      end else if (bus.instr_valid) begin
        if (is_call && full) bus.stack_overflow <= 1'b1;
        if (is_ret && empty) bus.stack_underflow <= 1'b1;
      end
    end
  logic [CW-1:0] unused_cw;
  assign unused_cw = '0;
endmodule
